// File: rtl/tmds_channel_encoder_if.sv
// Parallel-side bundle of one TMDS lane: symbol inputs toward the encoder,
// the registered 10-bit symbol and the running-disparity debug value back.
interface tmds_channel_encoder_if;
    logic [7:0] data_in;
    logic [2:0] mode;
    logic [1:0] ctrl_in;
    logic [3:0] terc4_in;
    logic [9:0] tmds_out;
    logic [4:0] disparity;

    modport master (
        output data_in, mode, ctrl_in, terc4_in,
        input  tmds_out, disparity
    );

    modport slave (
        input  data_in, mode, ctrl_in, terc4_in,
        output tmds_out, disparity
    );
endinterface

// File: rtl/tmds_channel_encoder.sv
// Single-lane TMDS/HDMI symbol encoder: control, video (8b/10b with DC balance),
// video guard band, TERC4 data island and island guard band, three-stage pipeline.
module tmds_channel_encoder #(
    parameter int CHANNEL = 0
) (
    input logic clk,
    input logic rst,
    tmds_channel_encoder_if.slave bus
);
    typedef enum logic [2:0] {
        MODE_CTRL   = 3'd0,
        MODE_VIDEO  = 3'd1,
        MODE_VGUARD = 3'd2,
        MODE_ISLAND = 3'd3,
        MODE_IGUARD = 3'd4
    } mode_t;

    // Out-of-range lane indices fall back to lane 0 behaviour.
    localparam int LANE = (CHANNEL > 2 || CHANNEL < 0) ? 0 : CHANNEL;
    localparam logic [9:0] GUARD_A = 10'b1011001100;
    localparam logic [9:0] GUARD_B = 10'b0100110011;

    function automatic logic [9:0] terc4_code(input logic [3:0] nib);
        logic [9:0] code;
        case (nib)
            4'h0: code = 10'b1010011100;
            4'h1: code = 10'b1001100011;
            4'h2: code = 10'b1011100100;
            4'h3: code = 10'b1011100010;
            4'h4: code = 10'b0101110001;
            4'h5: code = 10'b0100011110;
            4'h6: code = 10'b0110001110;
            4'h7: code = 10'b0100111100;
            4'h8: code = 10'b1011001100;
            4'h9: code = 10'b0100111001;
            4'hA: code = 10'b0110011100;
            4'hB: code = 10'b1011000110;
            4'hC: code = 10'b1010001110;
            4'hD: code = 10'b1001110001;
            4'hE: code = 10'b0101100011;
            default: code = 10'b1011000011;
        endcase
        return code;
    endfunction

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        logic [9:0] code;
        case (c)
            2'b00: code = 10'b1101010100;
            2'b01: code = 10'b0010101011;
            2'b10: code = 10'b0101010100;
            default: code = 10'b1010101011;
        endcase
        return code;
    endfunction

    mode_t mode_in, mode_s1, mode_s2;
    logic [1:0] ctrl_s1, ctrl_s2;
    logic [3:0] terc4_s1, terc4_s2;
    logic [7:0] data_s1;
    logic [3:0] n1_s1;
    logic       decision;
    logic [8:0] qm, qm_s2;
    logic [3:0] n1_s2, n0_s2;
    logic [4:0] diff, cnt_q, cnt_next;
    logic       cnt_zero, cnt_pos, cnt_neg;
    logic [9:0] out_q, out_next;

    always_comb begin
        case (bus.mode)
            3'd1:    mode_in = MODE_VIDEO;
            3'd2:    mode_in = MODE_VGUARD;
            3'd3:    mode_in = MODE_ISLAND;
            3'd4:    mode_in = MODE_IGUARD;
            default: mode_in = MODE_CTRL;
        endcase
    end

    // Side-band pipeline is reset so the lane emits control/00 until real input arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_s1  <= MODE_CTRL;
            ctrl_s1  <= 2'b00;
            terc4_s1 <= 4'h0;
            mode_s2  <= MODE_CTRL;
            ctrl_s2  <= 2'b00;
            terc4_s2 <= 4'h0;
        end else begin
            mode_s1  <= mode_in;
            ctrl_s1  <= bus.ctrl_in;
            terc4_s1 <= bus.terc4_in;
            mode_s2  <= mode_s1;
            ctrl_s2  <= ctrl_s1;
            terc4_s2 <= terc4_s1;
        end
    end

    always_ff @(posedge clk) begin
        data_s1 <= bus.data_in;
        n1_s1   <= 4'($countones(bus.data_in));
        qm_s2   <= qm;
        n1_s2   <= 4'($countones(qm[7:0]));
        n0_s2   <= 4'd8 - 4'($countones(qm[7:0]));
    end

    // Transition-minimising stage: XOR or XNOR chain picked by the ones count.
    always_comb begin
        logic acc;
        decision = (n1_s1 > 4'd4) || ((n1_s1 == 4'd4) && !data_s1[0]);
        qm       = '0;
        acc      = data_s1[0];
        qm[0]    = acc;
        for (int i = 1; i < 8; i++) begin
            acc   = acc ^ data_s1[i] ^ decision;
            qm[i] = acc;
        end
        qm[8] = ~decision;
    end

    always_comb begin
        diff     = {1'b0, n1_s2} - {1'b0, n0_s2};
        cnt_zero = (cnt_q == 5'd0);
        cnt_neg  = cnt_q[4];
        cnt_pos  = !cnt_q[4] && !cnt_zero;
        out_next = ctrl_code(ctrl_s2);
        cnt_next = 5'd0;
        case (mode_s2)
            MODE_VIDEO: begin
                if (cnt_zero || (n1_s2 == n0_s2)) begin
                    out_next = {~qm_s2[8], qm_s2[8], qm_s2[7:0] ^ {8{~qm_s2[8]}}};
                    cnt_next = qm_s2[8] ? (cnt_q + diff) : (cnt_q - diff);
                end else if ((cnt_pos && (n1_s2 > n0_s2)) || (cnt_neg && (n0_s2 > n1_s2))) begin
                    out_next = {1'b1, qm_s2[8], ~qm_s2[7:0]};
                    cnt_next = cnt_q + {3'b000, qm_s2[8], 1'b0} - diff;
                end else begin
                    out_next = {1'b0, qm_s2[8], qm_s2[7:0]};
                    cnt_next = cnt_q - {3'b000, ~qm_s2[8], 1'b0} + diff;
                end
            end
            MODE_VGUARD: out_next = (LANE == 1) ? GUARD_B : GUARD_A;
            MODE_ISLAND: out_next = terc4_code(terc4_s2);
            MODE_IGUARD: out_next = (LANE == 0) ? terc4_code({2'b11, ctrl_s2}) : GUARD_B;
            default:     out_next = ctrl_code(ctrl_s2);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= 10'd0;
            cnt_q <= 5'd0;
        end else begin
            out_q <= out_next;
            cnt_q <= cnt_next;
        end
    end

    assign bus.tmds_out  = out_q;
    assign bus.disparity = cnt_q;
endmodule
